path_result_writer: RTL

- Writes the computed A* path back into the HPS-visible shared memory region so the HPS can read it.
- Sits downstream of the pathfinding backtrace unit, which emits node IDs goal-to-start over a valid/ready stream.
- Layout in memory:
  - word 0 is a status word;
  - the node IDs follow;
  - a 16'hFFFF sentinel terminates the list. This is the same sentinel the HPS-to-FPGA node loader uses.

---
 rtl/path_result_writer_pkg.sv | 34 +++
 rtl/path_result_writer_if.sv | 36 +++
 rtl/path_result_writer_addr_gen.sv | 24 ++
 rtl/path_result_writer.sv | 139 +++++++++++++
 4 files changed

// File: rtl/path_result_writer_pkg.sv
// Shared types and constants for the A* path result writer.
// Holds the FSM state encoding, the end-of-path sentinel and the status word layout.
package path_writer_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        ACCEPT,
        WRITE_NODE,
        WRITE_TERM,
        WRITE_STATUS,
        DONE
    } path_state_e;

    localparam logic [15:0] PATH_SENTINEL   = 16'hFFFF;
    localparam int          STATUS_DONE_BIT = 15;
    localparam int          STATUS_OVF_BIT  = 14;
    localparam int          COUNT_W         = 14;

    function automatic logic is_write_state(input path_state_e s);
        return (s == CLEAR) || (s == WRITE_NODE) || (s == WRITE_TERM) || (s == WRITE_STATUS);
    endfunction

    // The HPS polls the done bit, so this word must be the final write of a result.
    function automatic logic [15:0] make_status(input logic ovf, input logic [COUNT_W-1:0] count);
        logic [15:0] w;
        w                  = '0;
        w[STATUS_DONE_BIT] = 1'b1;
        w[STATUS_OVF_BIT]  = ovf;
        w[COUNT_W-1:0]     = count;
        return w;
    endfunction

endpackage

// File: rtl/path_result_writer_if.sv
// Node stream, memory write bus and control/status signals of the path result writer.
// Defining PATH_WAITREQ_EN adds the mem_waitrequest back-pressure input.
interface path_result_writer_if;

    logic        path_start;
    logic        node_valid;
    logic        node_ready;
    logic [15:0] node_id;
    logic        node_last;
    logic        write_enable;
    logic [15:0] address;
    logic [15:0] writedata;
    logic        busy;
    logic        done;
    logic        overflow;
`ifdef PATH_WAITREQ_EN
    logic        mem_waitrequest;
`endif

    modport master (
`ifdef PATH_WAITREQ_EN
        input  mem_waitrequest,
`endif
        input  path_start, node_valid, node_id, node_last,
        output node_ready, write_enable, address, writedata, busy, done, overflow
    );

    modport slave (
`ifdef PATH_WAITREQ_EN
        output mem_waitrequest,
`endif
        output path_start, node_valid, node_id, node_last,
        input  node_ready, write_enable, address, writedata, busy, done, overflow
    );

endinterface

// File: rtl/path_result_writer_addr_gen.sv
// Byte address of the word written in a given state: the status word at BASE_ADDR,
// or the list slot BASE_ADDR+2+2*count for node and sentinel writes (16-bit wrap).
module path_result_addr_gen
    import path_writer_pkg::*;
#(
    parameter logic [15:0] BASE_ADDR = 16'h0900
) (
    input  path_state_e        state,
    input  logic [COUNT_W-1:0] count,
    output logic [15:0]        address
);

    logic [15:0] slot_offset;

    always_comb begin
        slot_offset = 16'd2 + {1'b0, count, 1'b0};
        if (state == WRITE_NODE || state == WRITE_TERM) begin
            address = BASE_ADDR + slot_offset;
        end else begin
            address = BASE_ADDR;
        end
    end

endmodule

// File: rtl/path_result_writer.sv
// Writes a backtraced A* path (status word, node IDs, 0xFFFF sentinel) into HPS shared memory.
// Optional macro PATH_WAITREQ_EN: stalls every write while mem_waitrequest is high.
module path_result_writer
    import path_writer_pkg::*;
#(
    parameter logic [15:0] BASE_ADDR = 16'h0900,
    parameter int          MAX_NODES = 64
) (
    input logic                 clk,
    input logic                 reset,
    path_result_writer_if.master bus
);

    localparam logic [COUNT_W-1:0] COUNT_MAX = COUNT_W'(MAX_NODES);

    path_state_e        state_q, state_d;
    logic [COUNT_W-1:0] count_q, count_d;
    logic [15:0]        lat_id_q, lat_id_d;
    logic               lat_last_q, lat_last_d;
    logic               overflow_q, overflow_d;
    logic               node_ready_q, node_ready_d;
    logic               write_enable_q, write_enable_d;
    logic [15:0]        address_q, address_d;
    logic [15:0]        writedata_q, writedata_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               stall;
    logic               handshake;
    logic [15:0]        slot_address;

    path_result_addr_gen #(.BASE_ADDR(BASE_ADDR)) u_addr_gen (
        .state   (state_d),
        .count   (count_d),
        .address (slot_address)
    );

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        lat_id_d   = lat_id_q;
        lat_last_d = lat_last_q;
        overflow_d = overflow_q;
        handshake  = bus.node_valid && node_ready_q;
`ifdef PATH_WAITREQ_EN
        stall      = is_write_state(state_q) && bus.mem_waitrequest;
`else
        stall      = 1'b0;
`endif
        if (!stall) begin
            case (state_q)
                IDLE: begin
                    if (bus.path_start) begin
                        state_d    = CLEAR;
                        count_d    = '0;
                        overflow_d = 1'b0;
                    end
                end
                CLEAR: state_d = ACCEPT;
                ACCEPT: begin
                    if (handshake) begin
                        if (bus.node_id == PATH_SENTINEL) begin
                            state_d = WRITE_TERM;
                        end else if (count_q < COUNT_MAX) begin
                            lat_id_d   = bus.node_id;
                            lat_last_d = bus.node_last;
                            state_d    = WRITE_NODE;
                        end else begin
                            // List is full: remember the loss but keep draining until the path ends.
                            overflow_d = 1'b1;
                            if (bus.node_last) begin
                                state_d = WRITE_TERM;
                            end
                        end
                    end
                end
                WRITE_NODE: begin
                    count_d = count_q + 1'b1;
                    state_d = lat_last_q ? WRITE_TERM : ACCEPT;
                end
                WRITE_TERM:   state_d = WRITE_STATUS;
                WRITE_STATUS: state_d = DONE;
                DONE:         state_d = IDLE;
                default:      state_d = IDLE;
            endcase
        end
    end

    // Outputs are decoded from the next state so they appear registered alongside it.
    always_comb begin
        node_ready_d   = (state_d == ACCEPT);
        write_enable_d = is_write_state(state_d);
        busy_d         = (state_d != IDLE) && (state_d != DONE);
        done_d         = (state_d == DONE);
        address_d      = write_enable_d ? slot_address : 16'h0000;
        case (state_d)
            WRITE_NODE:   writedata_d = lat_id_d;
            WRITE_TERM:   writedata_d = PATH_SENTINEL;
            WRITE_STATUS: writedata_d = make_status(overflow_d, count_d);
            default:      writedata_d = 16'h0000;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            count_q        <= '0;
            lat_id_q       <= '0;
            lat_last_q     <= 1'b0;
            overflow_q     <= 1'b0;
            node_ready_q   <= 1'b0;
            write_enable_q <= 1'b0;
            address_q      <= '0;
            writedata_q    <= '0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            count_q        <= count_d;
            lat_id_q       <= lat_id_d;
            lat_last_q     <= lat_last_d;
            overflow_q     <= overflow_d;
            node_ready_q   <= node_ready_d;
            write_enable_q <= write_enable_d;
            address_q      <= address_d;
            writedata_q    <= writedata_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
        end
    end

    assign bus.node_ready   = node_ready_q;
    assign bus.write_enable = write_enable_q;
    assign bus.address      = address_q;
    assign bus.writedata    = writedata_q;
    assign bus.busy         = busy_q;
    assign bus.done         = done_q;
    assign bus.overflow     = overflow_q;

endmodule
